multiply_add: RTL

Pipelined, fully throughput-capable multiply-accumulate computing `p = a * b + c`. It is the inverse of the pipelined divider: it reconstructs `N = D*Q + R` from divisor, quotient and remainder. Shift-add pipeline with one partial-product stage per multiplier bit, optional signed mode, valid tagging and clock-enable gating. It sits in the same arithmetic datapath as the divider, and the ws2812 colour-scaling logic uses it.

---
 rtl/multiply_add.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/multiply_add.sv
// multiply_add: pipelined p = a*b + c.
// One stage squares off the operands into sign + magnitude, b_len shift-add
// stages walk the multiplier magnitude MSB first, and a final stage restores
// the sign, adds the addend and flags results that do not fit in out_len bits.
// Valid is only a tag that rides along; data is computed every enabled cycle.
module multiply_add #(
    parameter int    a_len     = 8,
    parameter int    b_len     = 8,
    parameter int    c_len     = 8,
    parameter int    out_len   = 16,
    parameter string is_signed = "true"
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_ce,
    input  logic [a_len-1:0]   a,
    input  logic               a_valid,
    input  logic [b_len-1:0]   b,
    input  logic               b_valid,
    input  logic [c_len-1:0]   c,
    output logic [out_len-1:0] p,
    output logic               out_valid,
    output logic               overflow
);

    localparam bit SGN   = (is_signed == "true");
    localparam int ACC_W = a_len + b_len;
    localparam int W     = ACC_W + 1;

    // Stage 0 holds the operand magnitudes; stage k (1..b_len) holds the
    // partial accumulator after k multiplier bits. Magnitudes are only needed
    // up to the stage that consumes them, hence the shorter arrays.
    logic [a_len-1:0] a_mag_q [0:b_len-1];
    logic [a_len-1:0] a_mag_d [0:b_len-1];
    logic [b_len-1:0] b_mag_q [0:b_len-1];
    logic [b_len-1:0] b_mag_d [0:b_len-1];
    logic [ACC_W-1:0] acc_q   [1:b_len];
    logic [ACC_W-1:0] acc_d   [1:b_len];
    logic             s_q     [0:b_len];
    logic             s_d     [0:b_len];
    logic [c_len-1:0] c_q     [0:b_len];
    logic [c_len-1:0] c_d     [0:b_len];
    logic             vld_q   [0:b_len];
    logic             vld_d   [0:b_len];

    // Output stage
    logic [W-1:0]       acc_w;
    logic [W-1:0]       prod_w;
    logic [W-1:0]       c_ext;
    logic [W-1:0]       sum_w;
    logic [out_len-1:0] p_d;
    logic [out_len-1:0] p_q;
    logic               ov_d;
    logic               ov_q;
    logic               out_valid_d;
    logic               out_valid_q;

    // Next state of the input stage and the shift-add stages
    always_comb begin
        // Input stage: sign-magnitude split. The most negative value maps to
        // 2^(len-1), which still fits in len bits read as unsigned.
        a_mag_d[0] = a;
        b_mag_d[0] = b;
        s_d[0]     = 1'b0;
        if (SGN) begin
            if (a[a_len-1]) begin
                a_mag_d[0] = ~a + a_len'(1);
            end
            if (b[b_len-1]) begin
                b_mag_d[0] = ~b + b_len'(1);
            end
            s_d[0] = a[a_len-1] ^ b[b_len-1];
        end
        c_d[0]   = c;
        vld_d[0] = a_valid & b_valid;

        // Sign, addend and tag travel unchanged alongside every stage
        for (int k = 1; k <= b_len; k++) begin
            s_d[k]   = s_q[k-1];
            c_d[k]   = c_q[k-1];
            vld_d[k] = vld_q[k-1];
        end

        // Magnitudes are forwarded to the stages that still need them
        for (int k = 1; k < b_len; k++) begin
            a_mag_d[k] = a_mag_q[k-1];
            b_mag_d[k] = b_mag_q[k-1];
        end

        // First accumulate stage starts from zero and tests the multiplier MSB
        acc_d[1] = '0;
        if (b_mag_q[0][b_len-1]) begin
            acc_d[1] = ACC_W'(a_mag_q[0]);
        end

        // Stage k tests multiplier bit b_len-k: acc = 2*acc (+ a_mag)
        for (int k = 2; k <= b_len; k++) begin
            acc_d[k] = acc_q[k-1] << 1;
            if (b_mag_q[k-1][b_len-k]) begin
                acc_d[k] = (acc_q[k-1] << 1) + ACC_W'(a_mag_q[k-1]);
            end
        end
    end

    // Restore the sign in W bits and add the extended addend
    always_comb begin
        acc_w       = {1'b0, acc_q[b_len]};
        prod_w      = acc_w;
        if (s_q[b_len]) begin
            prod_w = ~acc_w + W'(1);
        end
        c_ext       = {{(W-c_len){SGN & c_q[b_len][c_len-1]}}, c_q[b_len]};
        sum_w       = prod_w + c_ext;
        out_valid_d = vld_q[b_len];
    end

    // Fit the W-bit sum into out_len bits; the branch depends only on widths
    generate
        if (out_len > W) begin : g_extend
            // Result always fits; widen with sign or zeros
            always_comb begin
                p_d  = {{(out_len-W){SGN & sum_w[W-1]}}, sum_w};
                ov_d = 1'b0;
            end
        end else if (out_len == W) begin : g_exact
            // Result always fits exactly
            always_comb begin
                p_d  = sum_w;
                ov_d = 1'b0;
            end
        end else begin : g_trunc
            logic [W-out_len:0] top_bits;
            // Truncate and check the discarded bits (plus the kept sign bit
            // in signed mode) for a lossless fit
            always_comb begin
                top_bits = sum_w[W-1:out_len-1];
                p_d      = sum_w[out_len-1:0];
                if (SGN) begin
                    ov_d = !((&top_bits) || !(|top_bits));
                end else begin
                    ov_d = |top_bits[W-out_len:1];
                end
            end
        end
    endgenerate

    // Pipeline registers: async clear, advance only on enabled edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < b_len; k++) begin
                a_mag_q[k] <= '0;
                b_mag_q[k] <= '0;
            end
            for (int k = 1; k <= b_len; k++) begin
                acc_q[k] <= '0;
            end
            for (int k = 0; k <= b_len; k++) begin
                s_q[k]   <= 1'b0;
                c_q[k]   <= '0;
                vld_q[k] <= 1'b0;
            end
            p_q         <= '0;
            ov_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clk_ce) begin
            for (int k = 0; k < b_len; k++) begin
                a_mag_q[k] <= a_mag_d[k];
                b_mag_q[k] <= b_mag_d[k];
            end
            for (int k = 1; k <= b_len; k++) begin
                acc_q[k] <= acc_d[k];
            end
            for (int k = 0; k <= b_len; k++) begin
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                vld_q[k] <= vld_d[k];
            end
            p_q         <= p_d;
            ov_q        <= ov_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign p         = p_q;
    assign overflow  = ov_q;
    assign out_valid = out_valid_q;

endmodule
